// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_ctrl_pkg
//  Purpose  : Shared encodings for the multi-cycle control FSM: state codes,
//             opcode values, ALUOp codes and PC source selects.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

    // State encoding is exported on the State debug port, so keep it fixed.
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DECODE   = 3'd2,
        ST_EXEC     = 3'd3,
        ST_MEM      = 3'd4,
        ST_WB       = 3'd5,
        ST_HALTED   = 3'd6,
        ST_STEPWAIT = 3'd7
    } state_t;

    // Opcodes, Instr[7:5]
    localparam logic [2:0] c_OP_ADD  = 3'b000;
    localparam logic [2:0] c_OP_SUB  = 3'b001;
    localparam logic [2:0] c_OP_ADDI = 3'b010;
    localparam logic [2:0] c_OP_LW   = 3'b011;
    localparam logic [2:0] c_OP_SW   = 3'b100;
    localparam logic [2:0] c_OP_BEQ  = 3'b101;
    localparam logic [2:0] c_OP_JMP  = 3'b110;
    localparam logic [2:0] c_OP_HALT = 3'b111;

    // ALU operations; 2'b10 (PASS_B) exists in the ALU but no opcode uses it.
    localparam logic [1:0] c_ALU_ADD = 2'b00;
    localparam logic [1:0] c_ALU_SUB = 2'b01;

    // PC source selects
    localparam logic [1:0] c_PC_INC    = 2'b00;
    localparam logic [1:0] c_PC_BRANCH = 2'b01;
    localparam logic [1:0] c_PC_JUMP   = 2'b10;

    // Instructions whose operand B comes from the sign-extended immediate.
    function automatic logic op_uses_imm(input logic [2:0] op);
        return (op == c_OP_ADDI) || (op == c_OP_LW) || (op == c_OP_SW);
    endfunction

    // Subtract for SUB and for the BEQ compare, add for everything else.
    function automatic logic [1:0] alu_op_for(input logic [2:0] op);
        return ((op == c_OP_SUB) || (op == c_OP_BEQ)) ? c_ALU_SUB : c_ALU_ADD;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wait_timer
//  Purpose  : Counts MEM cycles spent without MemReady. o_terminal fires in
//             the cycle whose increment brings the count to MAX_COUNT.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_wait_timer #(
    parameter int MAX_COUNT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_inc,
    output logic o_terminal
);

    localparam int CNT_W = $clog2(MAX_COUNT + 1);

    logic [CNT_W-1:0] r_count;

    // Wait counter: cleared outside MEM, saturates at MAX_COUNT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != CNT_W'(MAX_COUNT))) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_terminal = i_inc && (r_count == CNT_W'(MAX_COUNT - 1));

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_control
//  Purpose  : Multi-cycle control FSM for the 8-bit non-pipelined datapath.
//             FETCH -> DECODE -> EXEC -> [MEM] -> [WB], one instruction at a
//             time; drives all datapath strobes and mux selects (Moore style,
//             except BEQ's PCWrite which follows Zero in EXEC).
//  Config   : SINGLE_STEP_EN - when defined, instruction completion parks in
//             STEPWAIT until a rising edge on Step.
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_control
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W     = 3,
    parameter int ALUOP_W      = 2,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                Start,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                Zero,
    input  logic                MemReady,
    input  logic                Step,
    output logic                PCWrite,
    output logic [1:0]          PCSrc,
    output logic                IRWrite,
    output logic                RegWrite,
    output logic                ALUSrc,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                MemToReg,
    output logic                Halted,
    output logic                Error,
    output logic [2:0]          State
);

    state_t              r_state;
    state_t              w_next;
    logic [OPCODE_W-1:0] r_opreg;
    logic                r_error;
    logic                w_mem_clear;
    logic                w_mem_inc;
    logic                w_mem_timeout;
    logic                w_advance;

`ifdef SINGLE_STEP_EN
    // Completed instructions wait for the operator before the next fetch.
    localparam state_t c_RESUME = ST_STEPWAIT;

    logic r_step_d;

    // Previous Step level, so a held Step only releases one instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_step_d <= 1'b0;
        end else begin
            r_step_d <= Step;
        end
    end

    assign w_advance = Step && !r_step_d;
`else
    localparam state_t c_RESUME = ST_FETCH;

    logic w_unused_step;
    assign w_unused_step = Step;
    assign w_advance     = 1'b0;
`endif

    assign w_mem_clear = (r_state != ST_MEM);
    assign w_mem_inc   = (r_state == ST_MEM) && !MemReady;

    mem_wait_timer #(
        .MAX_COUNT (MEM_WAIT_MAX)
    ) u_mem_wait_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_mem_clear),
        .i_inc      (w_mem_inc),
        .o_terminal (w_mem_timeout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Opcode is captured once per instruction, in DECODE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opreg <= '0;
        end else if (r_state == ST_DECODE) begin
            r_opreg <= Opcode;
        end
    end

    // Sticky timeout flag; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_error <= 1'b0;
        end else if (w_mem_timeout) begin
            r_error <= 1'b1;
        end
    end

    // Next-state and strobe decode from the current state and latched opcode.
    always_comb begin
        w_next   = r_state;
        PCWrite  = 1'b0;
        PCSrc    = c_PC_INC;
        IRWrite  = 1'b0;
        RegWrite = 1'b0;
        ALUSrc   = 1'b0;
        ALUOp    = c_ALU_ADD;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        MemToReg = 1'b0;
        Halted   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (Start) begin
                    w_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                PCSrc   = c_PC_INC;
                w_next  = ST_DECODE;
            end
            ST_DECODE: begin
                w_next = (Opcode == c_OP_HALT) ? ST_HALTED : ST_EXEC;
            end
            ST_EXEC: begin
                ALUSrc = op_uses_imm(r_opreg);
                ALUOp  = alu_op_for(r_opreg);
                case (r_opreg)
                    c_OP_ADD, c_OP_SUB, c_OP_ADDI: w_next = ST_WB;
                    c_OP_LW, c_OP_SW:              w_next = ST_MEM;
                    c_OP_BEQ: begin
                        PCWrite = Zero;
                        PCSrc   = c_PC_BRANCH;
                        w_next  = c_RESUME;
                    end
                    c_OP_JMP: begin
                        PCWrite = 1'b1;
                        PCSrc   = c_PC_JUMP;
                        w_next  = c_RESUME;
                    end
                    default: w_next = ST_HALTED;
                endcase
            end
            ST_MEM: begin
                MemRead  = (r_opreg == c_OP_LW);
                MemWrite = (r_opreg == c_OP_SW);
                // A late MemReady still completes the access, even on the
                // cycle the timer would expire.
                if (MemReady) begin
                    w_next = (r_opreg == c_OP_LW) ? ST_WB : c_RESUME;
                end else if (w_mem_timeout) begin
                    w_next = ST_HALTED;
                end
            end
            ST_WB: begin
                RegWrite = 1'b1;
                MemToReg = (r_opreg == c_OP_LW);
                w_next   = c_RESUME;
            end
            ST_HALTED: begin
                Halted = 1'b1;
            end
`ifdef SINGLE_STEP_EN
            ST_STEPWAIT: begin
                if (w_advance) begin
                    w_next = ST_FETCH;
                end
            end
`endif
            default: begin
                w_next = w_advance ? ST_FETCH : ST_IDLE;
            end
        endcase
    end

    assign Error = r_error;
    assign State = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_control
//  Purpose  : Self-checking bench for multicycle_control. A trace model builds
//             the expected per-cycle strobe pattern of each instruction from
//             the instruction rules; stimulus noise comes from $urandom.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;
    import cpu_ctrl_pkg::*;

    localparam int         MEM_WAIT_MAX = 15;
    localparam logic [2:0] OPC_ADD  = 3'd0, OPC_SUB = 3'd1, OPC_ADDI = 3'd2,
                           OPC_LW   = 3'd3, OPC_SW  = 3'd4, OPC_BEQ  = 3'd5,
                           OPC_JMP  = 3'd6, OPC_HALT = 3'd7;

    typedef struct packed {
        logic [2:0] state;
        logic       pcwrite;
        logic [1:0] pcsrc;
        logic       irwrite;
        logic       regwrite;
        logic       alusrc;
        logic [1:0] aluop;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       halted;
        logic       error;
    } outs_t;

    typedef struct packed {
        outs_t o;
        logic  ready;
        logic  step;
    } trace_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       Start = 1'b0;
    logic [2:0] Opcode = 3'd0;
    logic       Zero = 1'b0;
    logic       MemReady = 1'b0;
    logic       Step = 1'b0;
    logic       PCWrite, IRWrite, RegWrite, ALUSrc, MemRead, MemWrite;
    logic       MemToReg, Halted, Error;
    logic [1:0] PCSrc, ALUOp;
    logic [2:0] State;
    outs_t      obs;

    int checks   = 0;
    int failures = 0;

    trace_t tq[$];
    outs_t  oq[$];

    multicycle_control #(
        .OPCODE_W     (3),
        .ALUOP_W      (2),
        .MEM_WAIT_MAX (MEM_WAIT_MAX)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .Start    (Start),
        .Opcode   (Opcode),
        .Zero     (Zero),
        .MemReady (MemReady),
        .Step     (Step),
        .PCWrite  (PCWrite),
        .PCSrc    (PCSrc),
        .IRWrite  (IRWrite),
        .RegWrite (RegWrite),
        .ALUSrc   (ALUSrc),
        .ALUOp    (ALUOp),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .MemToReg (MemToReg),
        .Halted   (Halted),
        .Error    (Error),
        .State    (State)
    );

    assign obs = {State, PCWrite, PCSrc, IRWrite, RegWrite, ALUSrc, ALUOp,
                  MemRead, MemWrite, MemToReg, Halted, Error};

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ------------------------------------------------------------------
    // Reference trace model
    // ------------------------------------------------------------------
    function automatic logic step_noise();
`ifdef SINGLE_STEP_EN
        return 1'b0;
`else
        return 1'($urandom);
`endif
    endfunction

    function automatic void add(input outs_t o, input logic rdy, input logic stp);
        tq.push_back({o, rdy, stp});
    endfunction

    function automatic outs_t blank(input logic [2:0] st);
        outs_t e;
        e = '0;
        e.state = st;
        return e;
    endfunction

    // Expected cycles of one instruction starting in FETCH. w = MEM cycles
    // without MemReady before it arrives; w >= MEM_WAIT_MAX means never.
    function automatic void build_trace(input logic [2:0] op, input logic z, input int w);
        outs_t e;
        int    nmem;
        tq.delete();
        e = blank(ST_FETCH); e.irwrite = 1'b1; e.pcwrite = 1'b1; e.pcsrc = 2'b00;
        add(e, 1'($urandom), step_noise());
        add(blank(ST_DECODE), 1'($urandom), step_noise());
        if (op == OPC_HALT) begin
            for (int i = 0; i < 4; i++) begin
                e = blank(ST_HALTED); e.halted = 1'b1;
                add(e, 1'($urandom), step_noise());
            end
            return;
        end
        e = blank(ST_EXEC);
        e.alusrc = (op == OPC_ADDI) || (op == OPC_LW) || (op == OPC_SW);
        e.aluop  = ((op == OPC_SUB) || (op == OPC_BEQ)) ? 2'b01 : 2'b00;
        if (op == OPC_BEQ) begin e.pcwrite = z;    e.pcsrc = 2'b01; end
        if (op == OPC_JMP) begin e.pcwrite = 1'b1; e.pcsrc = 2'b10; end
        add(e, 1'($urandom), step_noise());
        if ((op == OPC_LW) || (op == OPC_SW)) begin
            nmem = (w < MEM_WAIT_MAX) ? w + 1 : MEM_WAIT_MAX;
            for (int i = 0; i < nmem; i++) begin
                e = blank(ST_MEM);
                e.memread  = (op == OPC_LW);
                e.memwrite = (op == OPC_SW);
                add(e, (i == w), step_noise());
            end
            if (w >= MEM_WAIT_MAX) begin
                for (int i = 0; i < 4; i++) begin
                    e = blank(ST_HALTED); e.halted = 1'b1; e.error = 1'b1;
                    add(e, 1'($urandom), step_noise());
                end
                return;
            end
        end
        if ((op == OPC_ADD) || (op == OPC_SUB) || (op == OPC_ADDI) || (op == OPC_LW)) begin
            e = blank(ST_WB); e.regwrite = 1'b1; e.memtoreg = (op == OPC_LW);
            add(e, 1'($urandom), step_noise());
        end
`ifdef SINGLE_STEP_EN
        begin
            int nw;
            nw = $urandom_range(0, 2);
            for (int s = 0; s <= nw; s++) begin
                add(blank(ST_STEPWAIT), 1'($urandom), (s == nw));
            end
        end
`endif
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers (no checking)
    // ------------------------------------------------------------------
    task automatic do_reset();
        rst_n = 1'b0; Start = 1'b0; Step = 1'b0; MemReady = 1'b0;
        Zero = 1'b0; Opcode = 3'd0;
        #4;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic do_start();
        Start = 1'b1;
        @(posedge clk); #1;
        Start = 1'b0;
    endtask

    // Drives the trace's inputs cycle by cycle and records the outputs.
    task automatic play(input logic [2:0] op, input logic z);
        oq.delete();
        foreach (tq[i]) begin
            Start    = 1'($urandom);
            Opcode   = (tq[i].o.state == ST_DECODE) ? op : 3'($urandom);
            Zero     = (tq[i].o.state == ST_EXEC) ? z : 1'($urandom);
            MemReady = tq[i].ready;
            Step     = tq[i].step;
            #2;
            oq.push_back(obs);
            @(posedge clk); #1;
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        do_reset();
        #2;
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL reset_outputs observed=%h expected=%h", obs, 16'h0);
        end
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1; #2;
            checks++;
            if (obs !== '0) begin
                failures++;
                $display("FAIL idle_hold[%0d] observed=%h expected=%h", c, obs, 16'h0);
            end
        end
    endtask

    task automatic test_alu_addi();
        do_reset(); do_start();
        build_trace(OPC_ADDI, 1'b0, 0);
        play(OPC_ADDI, 1'b0);
        foreach (tq[i]) begin
            checks++;
            if (oq[i] !== tq[i].o) begin
                failures++;
                $display("FAIL addi[%0d] observed=%h expected=%h", i, oq[i], tq[i].o);
            end
        end
        Step = 1'b0;
        #2;
        checks++;
        if (State !== ST_FETCH) begin
            failures++;
            $display("FAIL addi_next_fetch observed=%0d expected=%0d", State, ST_FETCH);
        end
    endtask

    task automatic test_beq_jmp();
        logic [2:0] ops[3];
        logic       zs[3];
        ops[0] = OPC_BEQ; zs[0] = 1'b1;
        ops[1] = OPC_BEQ; zs[1] = 1'b0;
        ops[2] = OPC_JMP; zs[2] = 1'b0;
        do_reset(); do_start();
        for (int k = 0; k < 3; k++) begin
            build_trace(ops[k], zs[k], 0);
            play(ops[k], zs[k]);
            foreach (tq[i]) begin
                checks++;
                if (oq[i] !== tq[i].o) begin
                    failures++;
                    $display("FAIL branch%0d[%0d] observed=%h expected=%h", k, i, oq[i], tq[i].o);
                end
            end
        end
    endtask

    task automatic test_lw_wait();
        int nread;
        do_reset(); do_start();
        build_trace(OPC_LW, 1'b0, 3);
        play(OPC_LW, 1'b0);
        nread = 0;
        foreach (tq[i]) begin
            checks++;
            if (oq[i] !== tq[i].o) begin
                failures++;
                $display("FAIL lw_wait[%0d] observed=%h expected=%h", i, oq[i], tq[i].o);
            end
            if (oq[i].memread) nread++;
        end
        checks++;
        if (nread != 4) begin
            failures++;
            $display("FAIL lw_memread_cycles observed=%0d expected=4", nread);
        end
    endtask

    task automatic test_random();
        logic [2:0] op;
        logic       z;
        int         w;
        do_reset(); do_start();
        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 6));
            z  = 1'($urandom);
            w  = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 14) : $urandom_range(0, 3);
            build_trace(op, z, w);
            play(op, z);
            foreach (tq[i]) begin
                checks++;
                if (oq[i] !== tq[i].o) begin
                    failures++;
                    $display("FAIL random%0d op=%0d w=%0d [%0d] observed=%h expected=%h",
                             n, op, w, i, oq[i], tq[i].o);
                end
            end
        end
    endtask

    task automatic test_sw_timeout();
        int nwr;
        do_reset(); do_start();
        // MemReady on the last permitted cycle still completes the store.
        build_trace(OPC_SW, 1'b0, MEM_WAIT_MAX - 1);
        play(OPC_SW, 1'b0);
        foreach (tq[i]) begin
            checks++;
            if (oq[i] !== tq[i].o) begin
                failures++;
                $display("FAIL sw_late_ready[%0d] observed=%h expected=%h", i, oq[i], tq[i].o);
            end
        end
        build_trace(OPC_SW, 1'b0, MEM_WAIT_MAX);
        play(OPC_SW, 1'b0);
        nwr = 0;
        foreach (tq[i]) begin
            checks++;
            if (oq[i] !== tq[i].o) begin
                failures++;
                $display("FAIL sw_timeout[%0d] observed=%h expected=%h", i, oq[i], tq[i].o);
            end
            if (oq[i].memwrite) nwr++;
        end
        checks++;
        if (nwr != MEM_WAIT_MAX) begin
            failures++;
            $display("FAIL sw_timeout_mem_cycles observed=%0d expected=%0d", nwr, MEM_WAIT_MAX);
        end
    endtask

    task automatic test_halt();
        do_reset();
        #2;
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL reset_clears_error observed=%h expected=%h", obs, 16'h0);
        end
        do_start();
        build_trace(OPC_HALT, 1'b0, 0);
        play(OPC_HALT, 1'b0);
        foreach (tq[i]) begin
            checks++;
            if (oq[i] !== tq[i].o) begin
                failures++;
                $display("FAIL halt[%0d] observed=%h expected=%h", i, oq[i], tq[i].o);
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        do_reset(); do_start();
        build_trace(OPC_LW, 1'b0, 20);
        while (tq.size() > 5) void'(tq.pop_back());
        play(OPC_LW, 1'b0);
        foreach (tq[i]) begin
            checks++;
            if (oq[i] !== tq[i].o) begin
                failures++;
                $display("FAIL pre_reset[%0d] observed=%h expected=%h", i, oq[i], tq[i].o);
            end
        end
        MemReady = 1'b0; Step = 1'b0;
        #1;
        checks++;
        if (MemRead !== 1'b1) begin
            failures++;
            $display("FAIL mid_mem_memread observed=%b expected=1", MemRead);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL async_reset_outputs observed=%h expected=%h", obs, 16'h0);
        end
        #3;
        rst_n = 1'b1; Start = 1'b0;
        @(posedge clk); #1; #1;
        checks++;
        if (obs !== '0) begin
            failures++;
            $display("FAIL post_reset_idle observed=%h expected=%h", obs, 16'h0);
        end
        do_start();
        build_trace(OPC_LW, 1'b1, MEM_WAIT_MAX - 1);
        play(OPC_LW, 1'b1);
        foreach (tq[i]) begin
            checks++;
            if (oq[i] !== tq[i].o) begin
                failures++;
                $display("FAIL post_reset_lw[%0d] observed=%h expected=%h", i, oq[i], tq[i].o);
            end
        end
    endtask

`ifdef SINGLE_STEP_EN
    task automatic test_step();
        int nfetch;
        do_reset(); do_start();
        build_trace(OPC_ADD, 1'b0, 0);
        while (tq[$].o.state == ST_STEPWAIT) void'(tq.pop_back());
        play(OPC_ADD, 1'b0);
        foreach (tq[i]) begin
            checks++;
            if (oq[i] !== tq[i].o) begin
                failures++;
                $display("FAIL step_add[%0d] observed=%h expected=%h", i, oq[i], tq[i].o);
            end
        end
        nfetch = 0;
        for (int c = 0; c < 8; c++) begin
            Step = (c < 5); Opcode = OPC_ADD; MemReady = 1'b0; Start = 1'($urandom);
            #2;
            if (c == 0) begin
                checks++;
                if (obs !== blank(ST_STEPWAIT)) begin
                    failures++;
                    $display("FAIL stepwait_outputs observed=%h expected=%h", obs, blank(ST_STEPWAIT));
                end
            end
            if (IRWrite) nfetch++;
            if (c == 7) begin
                checks++;
                if (State !== ST_STEPWAIT) begin
                    failures++;
                    $display("FAIL step_parked observed=%0d expected=%0d", State, ST_STEPWAIT);
                end
            end
            @(posedge clk); #1;
        end
        checks++;
        if (nfetch != 1) begin
            failures++;
            $display("FAIL step_fetch_count observed=%0d expected=1", nfetch);
        end
        Step = 1'b1;
        @(posedge clk); #1; #1;
        checks++;
        if (State !== ST_FETCH) begin
            failures++;
            $display("FAIL step_release observed=%0d expected=%0d", State, ST_FETCH);
        end
        Step = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_alu_addi();
        test_beq_jmp();
        test_lw_wait();
        test_random();
        test_sw_timeout();
        test_halt();
        test_reset_mid_mem();
`ifdef SINGLE_STEP_EN
        test_step();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
